// File: rtl/arith_ctrl_pkg.sv
// Shared types and encodings for the arithmetic machine multi-cycle controller.
// Covers the FSM state, ALU operation codes, opcode/funct values and ALU B-mux selects.
package arith_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_INC = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/arith_ctrl_decode.sv
// Combinational instruction classifier for the R-type/I-type arithmetic subset.
// Anything outside the table, including opcode 0 with an unknown funct, is illegal.
module arith_ctrl_decode
    import arith_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic [1:0] src_b,
    output logic       rd_src,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        src_b   = SRCB_REG;
        rd_src  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_XOR:  alu_op = ALU_XOR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; src_b = SRCB_IMM; rd_src = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; src_b = SRCB_IMM; rd_src = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  src_b = SRCB_IMM; rd_src = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; src_b = SRCB_IMM; rd_src = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/arith_multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/WRITEBACK over one shared ALU.
// Halts sticky on an illegal instruction and counts retired instructions.
module arith_multicycle_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int PC_INC  = 4,
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               imem_ack,
    output logic               imem_req,
    output logic               pc_write,
    output logic               ir_write,
    output logic               ab_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               aluout_write,
    output logic               rd_src,
    output logic               reg_write,
    output logic               except,
    output logic               busy,
    output logic [COUNT_W-1:0] instret
);

    // PC_INC lives in the datapath's B-mux; the controller only selects it.
    if (PC_INC <= 0) begin : g_bad_pc_inc
        $error("PC_INC must be positive");
    end

    state_t       state, state_nxt;
    logic [2:0]   alu_op_q, dec_alu_op;
    logic [1:0]   src_b_q, dec_src_b;
    logic         rd_src_q, dec_rd_src, dec_illegal;
    logic         except_q;

    arith_ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (dec_alu_op),
        .src_b   (dec_src_b),
        .rd_src  (dec_rd_src),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = S_FETCH;
            S_FETCH:     if (imem_ack) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = dec_illegal ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = SRCB_INC;
                pc_write  = imem_ack;
                ir_write  = imem_ack;
            end
            S_DECODE: ab_write = 1'b1;
            S_EXECUTE: begin
                alu_src_a    = 1'b1;
                alu_src_b    = src_b_q;
                alu_op       = alu_op_q;
                aluout_write = 1'b1;
            end
            S_WRITEBACK: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign rd_src = rd_src_q;
    assign except = except_q;
    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXECUTE) || (state == S_WRITEBACK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_op_q <= '0;
            src_b_q  <= '0;
            rd_src_q <= 1'b0;
            except_q <= 1'b0;
            instret  <= '0;
        end else begin
            if (state == S_DECODE) begin
                alu_op_q <= dec_alu_op;
                src_b_q  <= dec_src_b;
                rd_src_q <= dec_rd_src;
                if (dec_illegal) except_q <= 1'b1;
            end
            if (state == S_WRITEBACK) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_arith_multicycle_ctrl.sv
// Directed bench for arith_multicycle_ctrl: decode table, fetch wait, halt, async reset, counter wrap.
// Counter width is shrunk to 4 bits so wrap-around is reachable quickly.
module tb_arith_multicycle_ctrl;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    opcode, funct;
    logic          imem_ack;
    logic          imem_req, pc_write, ir_write, ab_write, alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic          aluout_write, rd_src, reg_write, except, busy;
    logic [CW-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    arith_multicycle_ctrl #(.PC_INC(4), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .imem_ack(imem_ack), .imem_req(imem_req), .pc_write(pc_write),
        .ir_write(ir_write), .ab_write(ab_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .aluout_write(aluout_write),
        .rd_src(rd_src), .reg_write(reg_write), .except(except), .busy(busy),
        .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at negedge+1 with the DUT in FETCH.
    task automatic do_reset();
        reset = 1'b0; imem_ack = 1'b1;
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
    endtask

    // Starts and ends at negedge+1 in FETCH, imem_ack held high.
    task automatic run_legal(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] e_op,
                             input logic [1:0] e_b, input logic e_rd, input int e_cnt);
        int pcw;
        opcode = op; funct = fn; #1;
        chk("fetch_req", imem_req, 1);
        chk("fetch_ir", ir_write, 1);
        chk("fetch_srcb", alu_src_b, 2'b01);
        chk("fetch_aluop", alu_op, 3'b010);
        pcw = int'(pc_write);
        @(negedge clock); #1;
        chk("dec_ab", ab_write, 1);
        pcw += int'(pc_write);
        @(negedge clock); #1;
        chk("ex_srca", alu_src_a, 1);
        chk("ex_srcb", alu_src_b, e_b);
        chk("ex_aluop", alu_op, e_op);
        chk("ex_aluout", aluout_write, 1);
        pcw += int'(pc_write);
        @(negedge clock); #1;
        chk("wb_regw", reg_write, 1);
        chk("wb_rdsrc", rd_src, e_rd);
        pcw += int'(pc_write);
        chk("pc_once", pcw, 1);
        @(negedge clock); #1;
        chk("instret", instret, e_cnt);
        chk("back_fetch", imem_req, 1);
    endtask

    logic [5:0] t_op [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                              6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110};
    logic [5:0] t_fn [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                              6'b100110, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    logic [2:0] t_ao [10] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
                              3'b111, 3'b010, 3'b100, 3'b101, 3'b111};

    initial begin
        reset = 1'b0; imem_ack = 1'b1; opcode = 6'b001000; funct = 6'b0;
        @(negedge clock); #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_pcw", pc_write, 0);
        chk("rst_irw", ir_write, 0);
        chk("rst_aluop", alu_op, 3'b010);
        chk("rst_srcb", alu_src_b, 0);
        chk("rst_srca", alu_src_a, 0);
        chk("rst_except", except, 0);
        chk("rst_instret", instret, 0);
        reset = 1'b1;
        @(negedge clock); #1;

        // addi first (opcode 001000), then the full legal table
        run_legal(6'b001000, 6'b000000, 3'b010, 2'b10, 1'b1, 1);
        for (int i = 0; i < 10; i++)
            run_legal(t_op[i], t_fn[i], t_ao[i], (t_op[i] == 6'b0) ? 2'b00 : 2'b10,
                      (t_op[i] != 6'b0), i + 2);

        // three fetch wait cycles: instruction takes 7 cycles
        imem_ack = 1'b0; opcode = 6'b000000; funct = 6'b100010;
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("wait_req", imem_req, 1);
            chk("wait_pcw", pc_write, 0);
            chk("wait_irw", ir_write, 0);
            @(negedge clock); #1;
        end
        imem_ack = 1'b1; #1;
        chk("ack_pcw", pc_write, 1);
        chk("ack_irw", ir_write, 1);
        repeat (3) @(negedge clock);
        #1;
        chk("wait_wb", reg_write, 1);
        chk("wait_cnt_pre", instret, 11);
        @(negedge clock); #1;
        chk("wait_cnt", instret, 12);
        chk("wait_refetch", imem_req, 1);

        // illegal R-type funct -> HALT
        opcode = 6'b000000; funct = 6'b000001;
        @(negedge clock); #1;
        chk("ill_dec_ab", ab_write, 1);
        chk("ill_dec_exc", except, 0);
        @(negedge clock); #1;
        chk("halt_exc", except, 1);
        chk("halt_busy", busy, 0);
        chk("halt_regw", reg_write, 0);
        opcode = 6'b001000; funct = 6'b0;
        for (int k = 0; k < 4; k++) begin
            imem_ack = k[0];
            @(negedge clock); #1;
            chk("halt_req", imem_req, 0);
            chk("halt_pcw", pc_write, 0);
            chk("halt_sticky", except, 1);
        end
        chk("halt_cnt", instret, 12);

        // illegal opcode also halts
        do_reset();
        opcode = 6'b100011;
        repeat (2) @(negedge clock);
        #1;
        chk("ill_op_exc", except, 1);
        chk("ill_op_busy", busy, 0);

        // async reset in EXECUTE
        do_reset();
        opcode = 6'b001000;
        chk("rst2_exc", except, 0);
        repeat (2) @(negedge clock);
        #1;
        chk("pre_rst_aluout", aluout_write, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_aluout", aluout_write, 0);
        chk("arst_srca", alu_src_a, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", instret, 0);
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;

        // 17 addi: counter wraps 15 -> 0 -> 1
        for (int i = 1; i <= 17; i++) begin
            repeat (4) @(negedge clock);
            #1;
            if (i >= 15) chk("wrap_cnt", instret, i % 16);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
